// File: rtl/fpga_pll_rst_ctrl.sv
// Reset/lock supervisor for the HDMI pixel-clock MMCM: sequences RST pulses,
// qualifies the synchronized LOCKED signal, retries on timeout and latches failure.
module fpga_pll_rst_ctrl #(
    parameter int RST_CYCLES    = 8,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 64,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk_ext,
    input  logic             srst,
    input  logic             restart,
    input  logic             pll_lock_async,
    output logic             pll_rst,
    output logic             pll_ready,
    output logic             fail,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] lost_cnt
);

    localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int SC_W    = $clog2(CNT_MAX + 1);

    localparam logic [SC_W-1:0]  RST_LAST    = SC_W'(RST_CYCLES - 1);
    localparam logic [SC_W-1:0]  TIMEOUT_LAST = SC_W'(LOCK_TIMEOUT - 1);
    localparam logic [SC_W-1:0]  STABLE_LAST = SC_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT     = '1;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [SC_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d;
    logic [CNT_W-1:0] lost_cnt_q, lost_cnt_d;
    logic [CNT_W-1:0] retry_inc;
    logic             lock_meta_q, lock_meta_d;
    logic             lock_s_q, lock_s_d;
    logic             pll_rst_q, pll_rst_d;
    logic             pll_ready_q, pll_ready_d;
    logic             fail_q, fail_d;

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch can be inferred.
    always_comb begin
        lock_meta_d = pll_lock_async;
        lock_s_d    = lock_meta_q;
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        lost_cnt_d  = lost_cnt_q;
        retry_inc   = (retry_cnt_q == CNT_SAT) ? retry_cnt_q : retry_cnt_q + 1'b1;

        if (restart) begin
            state_d     = ST_RESET;
            retry_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_RESET: begin
                    if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_cnt_d = retry_inc;
                        state_d     = (int'(retry_inc) >= MAX_RETRIES) ? ST_FAIL : ST_RESET;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s_q)                state_d = ST_WAIT_LOCK;
                    else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!lock_s_q) begin
                        lost_cnt_d = (lost_cnt_q == CNT_SAT) ? lost_cnt_q : lost_cnt_q + 1'b1;
                        state_d    = ST_RESET;
                    end
                end
                ST_FAIL: ;
                default: state_d = ST_RESET;
            endcase
        end

        // The counter restarts on any state entry, including a restart re-entering RESET.
        if (restart || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (state_q inside {ST_RESET, ST_WAIT_LOCK, ST_STABLE}) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        pll_rst_d   = (state_d == ST_RESET) || (state_d == ST_FAIL);
        pll_ready_d = (state_d == ST_RUN);
        fail_d      = (state_d == ST_FAIL);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_ext) begin
        if (srst) begin
            state_q     <= ST_RESET;
            cnt_q       <= '0;
            retry_cnt_q <= '0;
            lost_cnt_q  <= '0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            pll_rst_q   <= 1'b1;
            pll_ready_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_cnt_q <= retry_cnt_d;
            lost_cnt_q  <= lost_cnt_d;
            lock_meta_q <= lock_meta_d;
            lock_s_q    <= lock_s_d;
            pll_rst_q   <= pll_rst_d;
            pll_ready_q <= pll_ready_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign pll_ready = pll_ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_cnt_q;
    assign lost_cnt  = lost_cnt_q;

endmodule
